// File: rtl/tlc_pkg.sv
// Shared codes for the traffic-light phase scheduler: state encodings, lamp encodings, rotation direction.
// Pure declarations, so there is no latency or backpressure here.
package tlc_pkg;

  localparam logic [2:0] S_NS_GREEN  = 3'd0;
  localparam logic [2:0] S_NS_YELLOW = 3'd1;
  localparam logic [2:0] S_ALL_RED   = 3'd2;
  localparam logic [2:0] S_EW_GREEN  = 3'd3;
  localparam logic [2:0] S_EW_YELLOW = 3'd4;
  localparam logic [2:0] S_PED_WALK  = 3'd5;

  typedef enum logic [2:0] {
    NS_GREEN  = S_NS_GREEN,
    NS_YELLOW = S_NS_YELLOW,
    ALL_RED   = S_ALL_RED,
    EW_GREEN  = S_EW_GREEN,
    EW_YELLOW = S_EW_YELLOW,
    PED_WALK  = S_PED_WALK
  } state_e;

  localparam logic [1:0] LT_RED    = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_GREEN  = 2'b10;

  typedef enum logic {
    NS = 1'b0,
    EW = 1'b1
  } dir_e;

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// Bundles the scheduler's demand inputs and its lamp/debug outputs.
// Level signals only: no handshake, so there is no latency or backpressure at this boundary.
interface tlc_phase_scheduler_if #(
  parameter int CNT_W = 4
);
  logic             ns_req;
  logic             ew_req;
  logic             ped_req;
  logic [1:0]       ns_light;
  logic [1:0]       ew_light;
  logic             walk;
  logic             ped_pending;
  logic [CNT_W-1:0] count;
  logic [2:0]       ps_state;

  modport master (
    output ns_req, ew_req, ped_req,
    input  ns_light, ew_light, walk, ped_pending, count, ps_state
  );

  modport slave (
    input  ns_req, ew_req, ped_req,
    output ns_light, ew_light, walk, ped_pending, count, ps_state
  );
endinterface

// File: rtl/tlc_phase_timer.sv
// Phase cycle counter: clears on request, optionally saturates, and flags a terminal value.
// count updates one edge after clr/sat_en; term is combinational from the registered count.
module tlc_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sat_en,
  input  logic [CNT_W-1:0] sat_val,
  input  logic [CNT_W-1:0] term_val,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!(sat_en && (count == sat_val))) begin
      count <= count + 1'b1;
    end
  end

  assign term = (count == term_val);

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Demand-driven NS/EW intersection sequencer with a latched pedestrian walk phase.
// Moore outputs from registered state; requests act on the next edge, and there is no backpressure.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW    = 3,
  parameter int ALLRED    = 1,
  parameter int WALK      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  tlc_phase_scheduler_if.slave  bus
);

  state_e           state_q;
  state_e           state_d;
  dir_e             next_dir;
  logic             ped_latched;
  logic             clr;
  logic             sat_en;
  logic             term;
  logic             green_ok;
  logic             entering_walk;
  logic [CNT_W-1:0] term_val;
  logic [CNT_W-1:0] count;

  tlc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .sat_en   (sat_en),
    .sat_val  (CNT_W'(GREEN_MAX - 1)),
    .term_val (term_val),
    .count    (count),
    .term     (term)
  );

  assign green_ok = (count >= CNT_W'(GREEN_MIN - 1));

  always_comb begin
    state_d  = state_q;
    term_val = '0;
    sat_en   = 1'b0;
    case (state_q)
      NS_GREEN: begin
        sat_en = 1'b1;
        if ((bus.ew_req || ped_latched) && green_ok) state_d = NS_YELLOW;
      end
      EW_GREEN: begin
        sat_en = 1'b1;
        if ((bus.ns_req || ped_latched) && green_ok) state_d = EW_YELLOW;
      end
      NS_YELLOW, EW_YELLOW: begin
        term_val = CNT_W'(YELLOW - 1);
        if (term) state_d = ALL_RED;
      end
      ALL_RED: begin
        term_val = CNT_W'(ALLRED - 1);
        if (term) begin
          if (ped_latched)          state_d = PED_WALK;
          else if (next_dir == NS)  state_d = NS_GREEN;
          else                      state_d = EW_GREEN;
        end
      end
      PED_WALK: begin
        term_val = CNT_W'(WALK - 1);
        if (term) state_d = ALL_RED;
      end
      default: state_d = ALL_RED;
    endcase
  end

  assign clr           = (state_d != state_q);
  assign entering_walk = (state_d == PED_WALK) && (state_q != PED_WALK);

  // The yellow that just finished decides which road gets green after clearance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= NS_GREEN;
      next_dir    <= EW;
      ped_latched <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == NS_YELLOW && state_d == ALL_RED) next_dir <= EW;
      if (state_q == EW_YELLOW && state_d == ALL_RED) next_dir <= NS;
      if (entering_walk)                              ped_latched <= 1'b0;
      else if (bus.ped_req && state_q != PED_WALK)    ped_latched <= 1'b1;
    end
  end

  always_comb begin
    bus.ns_light = LT_RED;
    bus.ew_light = LT_RED;
    bus.walk     = 1'b0;
    case (state_q)
      NS_GREEN:  bus.ns_light = LT_GREEN;
      NS_YELLOW: bus.ns_light = LT_YELLOW;
      EW_GREEN:  bus.ew_light = LT_GREEN;
      EW_YELLOW: bus.ew_light = LT_YELLOW;
      PED_WALK:  bus.walk     = 1'b1;
      default: ;
    endcase
  end

  assign bus.ped_pending = ped_latched;
  assign bus.count       = count;
  assign bus.ps_state    = state_q;

endmodule
